// File: rtl/traffic_ctrl.sv
// Two-road traffic-light controller: one-second tick prescaler, phase
// sequencer with per-phase durations, night flashing-yellow mode.
//
// Optional feature macro: TRAFFIC_PED_EN
//   defined   -> pedestrian latch shortens road A green, ped_ack pulses
//   undefined -> ped_req ignored, ped_ack tied 0, fixed durations
//
// Ports:
//   sysclk   in   system clock
//   rst      in   asynchronous reset, active-high
//   night    in   level, 1 selects flashing-yellow mode (sampled on tick)
//   ped_req  in   pedestrian request for crossing road A (pulse or level)
//   light1   out  road A {r,g,b}: red=100 yellow=110 green=010 off=000
//   light2   out  road B, same encoding
//   remain   out  ticks left in the current phase, 0 in FLASH
//   phase    out  state code 0..6
//   ped_ack  out  one-cycle pulse when a request is consumed
module traffic_ctrl #(
    parameter int TICK_DIV    = 125000000,
    parameter int CNT_W       = 8,
    parameter int GREEN_S     = 30,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int MIN_GREEN_S = 5
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             night,
    input  logic             ped_req,
    output logic [2:0]       light1,
    output logic [2:0]       light2,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase,
    output logic             ped_ack
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    localparam logic [CNT_W-1:0] D_GREEN  = CNT_W'(GREEN_S);
    localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b110;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] OFF = 3'b000;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        A_GREEN   = 3'd1,
        A_YELLOW  = 3'd2,
        ALL_RED_B = 3'd3,
        B_GREEN   = 3'd4,
        B_YELLOW  = 3'd5,
        FLASH     = 3'd6
    } state_t;

    state_t          state;
    state_t          state_d;
    state_t          seq_next;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic [CNT_W-1:0] remain_d;
    logic [CNT_W-1:0] seq_dur;
    logic            flash_on;
    logic            flash_d;
    logic [2:0]      light1_d;
    logic [2:0]      light2_d;
    logic            night_go;
    logic            advance;

    assign tick     = (prescaler == TICK_LAST);
    assign phase    = state;
    // Night entry wins over a normal advance on the same tick.
    assign night_go = tick && night && (state != FLASH);
    assign advance  = tick && !night && (state != FLASH)
                      && (remain == ONE);

    // Successor in the normal six-phase rotation and its duration.
    always_comb begin
        seq_next = ALL_RED_A;
        seq_dur  = D_ALLRED;
        unique case (state)
            ALL_RED_A: begin
                seq_next = A_GREEN;
                seq_dur  = D_GREEN;
            end
            A_GREEN: begin
                seq_next = A_YELLOW;
                seq_dur  = D_YELLOW;
            end
            A_YELLOW: begin
                seq_next = ALL_RED_B;
                seq_dur  = D_ALLRED;
            end
            ALL_RED_B: begin
                seq_next = B_GREEN;
                seq_dur  = D_GREEN;
            end
            B_GREEN: begin
                seq_next = B_YELLOW;
                seq_dur  = D_YELLOW;
            end
            B_YELLOW: begin
                seq_next = ALL_RED_A;
                seq_dur  = D_ALLRED;
            end
            default: begin
                seq_next = ALL_RED_A;
                seq_dur  = D_ALLRED;
            end
        endcase
    end

`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] D_MIN = CNT_W'(MIN_GREEN_S);

    logic ped_pend;
    logic pend_d;
    logic ack_d;
    logic consume;

    // A request is only consumed in A_GREEN on a cycle that does not
    // leave A_GREEN (neither a phase advance nor a night entry).
    assign consume = (state == A_GREEN) && ped_pend
                     && !advance && !night_go;
`endif

    // Next state, remain and flash phase.
    always_comb begin
        state_d  = state;
        remain_d = remain;
        flash_d  = flash_on;
        if (state == FLASH) begin
            if (tick) begin
                if (night) begin
                    flash_d = ~flash_on;
                end else begin
                    state_d  = ALL_RED_A;
                    remain_d = D_ALLRED;
                    flash_d  = 1'b1;
                end
            end
        end else if (night_go) begin
            state_d  = FLASH;
            remain_d = '0;
            flash_d  = 1'b1;
        end else if (advance) begin
            state_d  = seq_next;
            remain_d = seq_dur;
        end else if (tick) begin
            remain_d = remain - ONE;
        end
`ifdef TRAFFIC_PED_EN
        // Shortening overrides any tick decrement in the same cycle.
        if (consume && (remain > D_MIN)) begin
            remain_d = D_MIN;
        end
`endif
    end

`ifdef TRAFFIC_PED_EN
    always_comb begin
        pend_d = ped_pend;
        ack_d  = 1'b0;
        if (ped_req) begin
            pend_d = 1'b1;
        end
        if (consume) begin
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end
        if (night_go) begin
            pend_d = 1'b0;
        end
    end
`endif

    // Lights are decoded from the next state so they are registered
    // alongside it and change in the same cycle.
    always_comb begin
        light1_d = RED;
        light2_d = RED;
        unique case (state_d)
            A_GREEN:  light1_d = GRN;
            A_YELLOW: light1_d = YEL;
            B_GREEN:  light2_d = GRN;
            B_YELLOW: light2_d = YEL;
            FLASH: begin
                light1_d = flash_d ? YEL : OFF;
                light2_d = flash_d ? YEL : OFF;
            end
            default: begin
                light1_d = RED;
                light2_d = RED;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state    <= ALL_RED_A;
            remain   <= D_ALLRED;
            flash_on <= 1'b1;
            light1   <= RED;
            light2   <= RED;
        end else begin
            state    <= state_d;
            remain   <= remain_d;
            flash_on <= flash_d;
            light1   <= light1_d;
            light2   <= light2_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            ped_pend <= pend_d;
            ped_ack  <= ack_d;
        end
    end
`else
    logic             unused_ped;
    logic [CNT_W-1:0] unused_min;

    assign unused_ped = ped_req;
    assign unused_min = CNT_W'(MIN_GREEN_S);
    assign ped_ack    = 1'b0;
`endif

endmodule
